lc3_mem_arbiter: RTL
====================

// Module: lc3_mem_arbiter
// PURPOSE
//  Shares the single LC-3 memory port (addr/din/dout/rd/complete) between two requesters:
//  port 0 = LC-3 core (fetch, indirect, load/store), port 1 = program loader / debug master.
//  Round-robin grant, one transaction in flight, latched request, completion timeout.
//  Sits between the core's memory interface and the external memory model.
// PARAMETERS
//  AW       16  address width
//  DW       16  data width
//  TIMEOUT  15  BUSY cycles without complete before transaction is aborted (1..255)
// PORTS
//  clock     in   1   rising-edge clock
//  reset     in   1   synchronous, active-high reset
//  req0      in   1   port 0 request; held high until done0
//  rd0       in   1   port 0 direction: 1 = read, 0 = write
//  addr0     in   AW  port 0 address
//  din0      in   DW  port 0 write data
//  gnt0      out  1   port 0 owns memory (registered)
//  done0     out  1   port 0 transaction finished, one-cycle pulse
//  dout0     out  DW  port 0 read data, valid with done0, held until next port 0 read
//  req1/rd1/addr1/din1/gnt1/done1/dout1  -- identical set for port 1
//  mem_en    out  1   memory access active
//  mem_rd    out  1   1 = read, 0 = write
//  mem_addr  out  AW  memory address
//  mem_din   out  DW  memory write data
//  mem_dout  in   DW  memory read data, valid with complete
//  complete  in   1   memory finished current access
//  err       out  1   timeout pulse, coincident with the aborted port's done
// BEHAVIOUR
//  Reset: state IDLE; gnt*, done*, err, mem_en = 0; mem_rd = 1; mem_addr, mem_din, dout* = 0;
//   rr pointer -> port 0 wins first tie; timeout counter = 0. Reset mid-BUSY abandons access, no done.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: sample req0/req1. One requesting -> grant it. Both -> grant port not served last.
//   On grant: latch rd/addr/din of winner, set gnt, counter = 0, go BUSY next edge.
//  BUSY: mem_en = 1, mem_rd = latched rd, mem_addr = latched addr,
//   mem_din = latched din on write, 0 on read. Counter increments each BUSY cycle.
//   complete = 1 -> on read capture mem_dout into winner's dout; go RESP.
//   counter == TIMEOUT-1 with complete = 0 -> set err flag, dout unchanged; go RESP.
//   complete and timeout in same cycle -> complete wins, no err.
//  RESP: mem_en = 0, mem_rd = 1; winner's done = 1 (and err if timed out) for exactly this
//   cycle; gnt cleared on exit; rr pointer updated to winner; next state IDLE.
//  Latency: req seen in IDLE at edge N -> gnt/mem_en high after N; complete at edge M
//   -> done high after M. Minimum 3 cycles per transaction, one IDLE cycle between grants.
//  Requesters drop req in the done cycle; req changes during BUSY/RESP are ignored.
//  complete outside BUSY is ignored. Latched fields never change while BUSY.
//  Non-granted port: gnt, done stay 0; its dout holds.
// TESTING
//  1 Single read: req0=1, rd0=1, addr0=16'h3000; complete after 2 BUSY cycles with mem_dout=16'h1234
//    -> mem_addr=3000, mem_rd=1 in BUSY; done0 one pulse, dout0=1234, err=0.
//  2 Write: req1=1, rd1=0, addr1=16'h4000, din1=16'hBEEF -> mem_rd=0, mem_din=BEEF in BUSY; done1 pulse.
//  3 Contention: req0 and req1 held high continuously -> grants alternate 0,1,0,1 after reset,
//    never two gnt simultaneously, one IDLE cycle between grants.
//  4 Timeout: req0 read, complete never asserted -> done0 and err pulse after TIMEOUT BUSY cycles,
//    dout0 unchanged; late complete in IDLE ignored; next req1 served normally.
//  5 Reset mid-BUSY: reset while port 1 in BUSY -> next cycle all outputs at reset values, no done1;
//    then simultaneous requests -> port 0 granted first.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one LC-3 memory port between the core (port 0) and a
// loader/debug master (port 1). Round-robin on ties, one access in flight,
// request fields latched at grant, and an access that never completes is aborted
// after TIMEOUT busy cycles and reported with err alongside the owner's done.
module lc3_mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          rd0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] dout0,
  input  logic          req1,
  input  logic          rd1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] dout1,
  output logic          mem_en,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          complete,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last busy cycle index before an access is declared dead.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t        state_r, state_s;
  logic          owner_r, owner_s;   // port holding the current grant
  logic          last_r, last_s;     // port served most recently (tie-break)
  logic [7:0]    cnt_r, cnt_s;
  logic          pick_s;
  logic          gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic          done0_r, done0_s, done1_r, done1_s;
  logic          err_r, err_s;
  logic          mem_en_r, mem_en_s;
  logic          mem_rd_r, mem_rd_s;  // doubles as the latched direction
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [DW-1:0] mem_din_r, mem_din_s;
  logic [DW-1:0] dout0_r, dout0_s, dout1_r, dout1_s;

  assign gnt0     = gnt0_r;
  assign gnt1     = gnt1_r;
  assign done0    = done0_r;
  assign done1    = done1_r;
  assign err      = err_r;
  assign mem_en   = mem_en_r;
  assign mem_rd   = mem_rd_r;
  assign mem_addr = mem_addr_r;
  assign mem_din  = mem_din_r;
  assign dout0    = dout0_r;
  assign dout1    = dout1_r;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    last_s     = last_r;
    cnt_s      = cnt_r;
    pick_s     = 1'b0;
    gnt0_s     = gnt0_r;
    gnt1_s     = gnt1_r;
    done0_s    = 1'b0;
    done1_s    = 1'b0;
    err_s      = 1'b0;
    mem_en_s   = mem_en_r;
    mem_rd_s   = mem_rd_r;
    mem_addr_s = mem_addr_r;
    mem_din_s  = mem_din_r;
    dout0_s    = dout0_r;
    dout1_s    = dout1_r;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that was not served last wins.
          if (req0 && req1) begin
            pick_s = ~last_r;
          end else if (req1) begin
            pick_s = 1'b1;
          end else begin
            pick_s = 1'b0;
          end
          owner_s  = pick_s;
          gnt0_s   = ~pick_s;
          gnt1_s   = pick_s;
          cnt_s    = 8'd0;
          mem_en_s = 1'b1;
          if (pick_s) begin
            mem_rd_s   = rd1;
            mem_addr_s = addr1;
            mem_din_s  = rd1 ? {DW{1'b0}} : din1;
          end else begin
            mem_rd_s   = rd0;
            mem_addr_s = addr0;
            mem_din_s  = rd0 ? {DW{1'b0}} : din0;
          end
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        cnt_s = cnt_r + 8'd1;
        // A completion in the final busy cycle beats the timeout.
        if (complete) begin
          if (mem_rd_r && owner_r) begin
            dout1_s = mem_dout;
          end else if (mem_rd_r) begin
            dout0_s = mem_dout;
          end else begin
            dout0_s = dout0_r;
          end
          done0_s  = ~owner_r;
          done1_s  = owner_r;
          mem_en_s = 1'b0;
          mem_rd_s = 1'b1;
          state_s  = RESP;
        end else if (cnt_r == TIMEOUT_LAST) begin
          done0_s  = ~owner_r;
          done1_s  = owner_r;
          err_s    = 1'b1;
          mem_en_s = 1'b0;
          mem_rd_s = 1'b1;
          state_s  = RESP;
        end else begin
          state_s = BUSY;
        end
      end
      RESP: begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        last_s  = owner_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      owner_r    <= 1'b0;
      last_r     <= 1'b1;
      cnt_r      <= 8'd0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      err_r      <= 1'b0;
      mem_en_r   <= 1'b0;
      mem_rd_r   <= 1'b1;
      mem_addr_r <= {AW{1'b0}};
      mem_din_r  <= {DW{1'b0}};
      dout0_r    <= {DW{1'b0}};
      dout1_r    <= {DW{1'b0}};
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      last_r     <= last_s;
      cnt_r      <= cnt_s;
      gnt0_r     <= gnt0_s;
      gnt1_r     <= gnt1_s;
      done0_r    <= done0_s;
      done1_r    <= done1_s;
      err_r      <= err_s;
      mem_en_r   <= mem_en_s;
      mem_rd_r   <= mem_rd_s;
      mem_addr_r <= mem_addr_s;
      mem_din_r  <= mem_din_s;
      dout0_r    <= dout0_s;
      dout1_r    <= dout1_s;
    end
  end

endmodule
